// File: rtl/rom_streamer.sv
// Walks a contiguous ROM address range and streams each word over valid/ready, then pulses done.
// Optional burst XOR checksum is built only when ROM_STREAMER_CHECKSUM_EN is defined.
module rom_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    handshake  = 1'b0;
    case (state)
      IDLE: if (start) state_next = (len != '0) ? LOAD : DONE;
      LOAD: state_next = SEND;
      SEND: begin
        handshake = m_valid && m_ready;
        if (handshake) state_next = (remaining != '0) ? LOAD : DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are derived from the next state so they line up with the registered state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr  <= start_addr;
            remaining <= len;
          end
        end
        LOAD: begin
          m_data    <= rom_data;
          m_valid   <= 1'b1;
          rom_addr  <= rom_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        SEND: begin
          if (handshake) m_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_STREAMER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (handshake)            checksum <= checksum ^ m_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// Directed self-checking bench for rom_streamer with a small combinational ROM model.
module tb_rom_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] len;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  rom_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] got [$];
  int done_cnt, valid_seen, first_valid_c, done_c, idle_c, stalls;
  logic [7:0] chk_at_done;
  logic finished;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_chk(input logic [7:0] v);
`ifdef ROM_STREAMER_CHECKSUM_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one burst and observes it until the streamer returns to idle.
  task automatic burst(input logic [7:0] sa, input logic [8:0] l, input int stall_n, input bit mid_start);
    got.delete();
    done_cnt = 0; valid_seen = 0; first_valid_c = -1; done_c = -1; idle_c = -1;
    stalls = 0; finished = 1'b0; chk_at_done = 8'hxx;
    start_addr = sa; len = l; start = 1'b1; m_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        done_cnt++;
        done_c = c;
        chk_at_done = checksum;
      end
      if (m_valid) begin
        valid_seen++;
        if (first_valid_c < 0) first_valid_c = c;
      end
      if (stall_n > 0 && got.size() == 1 && stalls < stall_n && (stalls > 0 || m_valid)) begin
        check("bp_valid_hold", m_valid, 1);
        check("bp_data_hold", m_data, 8'h15);
        m_ready = 1'b0;
        stalls++;
      end else begin
        m_ready = 1'b1;
        if (m_valid) got.push_back(m_data);
      end
      if (mid_start && c == 3) begin
        start = 1'b1; start_addr = 8'h03; len = 9'd1;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        idle_c = c;
        finished = 1'b1;
        break;
      end
      step();
    end
    m_ready = 1'b1;
    check("burst_terminated", finished, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h09; rom[1] = 8'h15; rom[2] = 8'h1C; rom[3] = 8'h2A; rom[255] = 8'h77;
    rst = 1'b1; start = 1'b0; start_addr = 8'h00; len = 9'd0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_rom_addr", rom_addr, 8'h00);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 8'h00);

    // Full burst, first cycles checked explicitly for latency
    start_addr = 8'h00; len = 9'd4; start = 1'b1; m_ready = 1'b1;
    step();
    start = 1'b0;
    check("full_e0_busy", busy, 1);
    check("full_e0_valid", m_valid, 0);
    check("full_e0_addr", rom_addr, 8'h00);
    step();
    check("full_e1_valid", m_valid, 1);
    check("full_e1_data", m_data, 8'h09);
    repeat (8) step();
    check("full_idle_busy", busy, 0);
    check("full_end_addr", rom_addr, 8'h04);
    check("full_checksum", checksum, exp_chk(8'h2A));

    burst(8'h00, 9'd4, 0, 1'b0);
    check("full2_count", got.size(), 4);
    check("full2_w0", got[0], 8'h09);
    check("full2_w1", got[1], 8'h15);
    check("full2_w2", got[2], 8'h1C);
    check("full2_w3", got[3], 8'h2A);
    check("full2_first_valid", first_valid_c, 1);
    check("full2_done_cnt", done_cnt, 1);
    check("full2_done_cycle", done_c, 8);
    check("full2_busy_fall", idle_c, 9);
    check("full2_chk_done", chk_at_done, exp_chk(8'h2A));
    check("full2_addr", rom_addr, 8'h04);

    // Backpressure on the second word
    burst(8'h00, 9'd4, 3, 1'b0);
    check("bp_stalls", stalls, 3);
    check("bp_count", got.size(), 4);
    check("bp_w0", got[0], 8'h09);
    check("bp_w1", got[1], 8'h15);
    check("bp_w2", got[2], 8'h1C);
    check("bp_w3", got[3], 8'h2A);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_done_cycle", done_c, 11);
    check("bp_chk", checksum, exp_chk(8'h2A));

    // Wrap-around
    burst(8'hFF, 9'd2, 0, 1'b0);
    check("wrap_count", got.size(), 2);
    check("wrap_w0", got[0], 8'h77);
    check("wrap_w1", got[1], 8'h09);
    check("wrap_addr", rom_addr, 8'h01);
    check("wrap_chk", checksum, exp_chk(8'h7E));
    check("wrap_done_cnt", done_cnt, 1);

    // Zero length
    burst(8'h05, 9'd0, 0, 1'b0);
    check("zero_valid_seen", valid_seen, 0);
    check("zero_done_cycle", done_c, 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_busy_fall", idle_c, 1);
    check("zero_addr", rom_addr, 8'h05);
    check("zero_chk", checksum, 8'h00);

    // Start while busy is ignored
    burst(8'h00, 9'd4, 0, 1'b1);
    check("ign_count", got.size(), 4);
    check("ign_w0", got[0], 8'h09);
    check("ign_w1", got[1], 8'h15);
    check("ign_w2", got[2], 8'h1C);
    check("ign_w3", got[3], 8'h2A);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_addr", rom_addr, 8'h04);
    repeat (3) step();
    check("ign_no_restart", busy, 0);

    // Asynchronous reset during the SEND of word 2
    start_addr = 8'h00; len = 9'd4; start = 1'b1; m_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("mid_pre_valid", m_valid, 1);
    check("mid_pre_data", m_data, 8'h15);
    m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", rom_addr, 8'h00);
    check("mid_rst_chk", checksum, 8'h00);
    check("mid_rst_done", done, 0);
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    step();
    check("mid_post_done", done, 0);
    check("mid_post_busy", busy, 0);

    burst(8'h02, 9'd2, 0, 1'b0);
    check("post_count", got.size(), 2);
    check("post_w0", got[0], 8'h1C);
    check("post_w1", got[1], 8'h2A);
    check("post_addr", rom_addr, 8'h04);
    check("post_chk", checksum, exp_chk(8'h36));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
